// File: rtl/sdr_ch3_arbiter.sv
// SDRAM channel 3 arbiter between the CPU requester and the ROM loader (toggle handshakes).
// Optional downstream watchdog: define SDR_ARB_TIMEOUT_EN to enable timeout_err and request withdrawal.
//
// state | meaning
// IDLE  | no access in flight; pick a pending requester (ROM first while rom_load_busy)
// WAIT  | command issued to the controller; waiting for sdr_ack == sdr_req
module sdr_ch3_arbiter #(
  parameter int AW      = 27,
  parameter int DW      = 16,
  parameter int QW      = 64,
  parameter int TIMEOUT = 4095
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rom_load_busy,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  input  logic [1:0]    cpu_be,
  input  logic          cpu_rw,
  input  logic          cpu_req,
  output logic          cpu_ack,
  output logic [QW-1:0] cpu_q,
  input  logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_din,
  input  logic [1:0]    rom_be,
  input  logic          rom_rw,
  input  logic          rom_req,
  output logic          rom_ack,
  output logic [AW-1:0] sdr_addr,
  output logic [DW-1:0] sdr_din,
  output logic [1:0]    sdr_be,
  output logic          sdr_rnw,
  output logic          sdr_req,
  input  logic          sdr_ack,
  input  logic [QW-1:0] sdr_q,
  output logic          timeout_err
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t        state, state_nxt;
  logic          owner_rom, owner_rom_nxt;
  logic          cpu_ack_nxt, rom_ack_nxt, sdr_req_nxt, sdr_rnw_nxt;
  logic [AW-1:0] sdr_addr_nxt;
  logic [DW-1:0] sdr_din_nxt;
  logic [1:0]    sdr_be_nxt;
  logic [QW-1:0] cpu_q_nxt;
  logic          pick_rom;

  wire cpu_pend = cpu_req ^ cpu_ack;
  wire rom_pend = rom_req ^ rom_ack;

`ifdef SDR_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [CW-1:0] cnt, cnt_nxt;
  logic          timeout_err_nxt;
`else
  // Watchdog absent: flag tied low, TIMEOUT has no effect.
  assign timeout_err = 1'b0 & (TIMEOUT == 0);
`endif

  always_comb begin
    state_nxt     = state;
    owner_rom_nxt = owner_rom;
    cpu_ack_nxt   = cpu_ack;
    rom_ack_nxt   = rom_ack;
    sdr_req_nxt   = sdr_req;
    sdr_rnw_nxt   = sdr_rnw;
    sdr_addr_nxt  = sdr_addr;
    sdr_din_nxt   = sdr_din;
    sdr_be_nxt    = sdr_be;
    cpu_q_nxt     = cpu_q;
    pick_rom      = 1'b0;
`ifdef SDR_ARB_TIMEOUT_EN
    cnt_nxt         = cnt;
    timeout_err_nxt = timeout_err;
`endif
    case (state)
      IDLE: begin
        if (cpu_pend || rom_pend) begin
          pick_rom      = rom_pend && (rom_load_busy || !cpu_pend);
          owner_rom_nxt = pick_rom;
          sdr_addr_nxt  = pick_rom ? rom_addr : cpu_addr;
          sdr_din_nxt   = pick_rom ? rom_din  : cpu_din;
          sdr_be_nxt    = pick_rom ? rom_be   : cpu_be;
          sdr_rnw_nxt   = pick_rom ? rom_rw   : cpu_rw;
          sdr_req_nxt   = ~sdr_req;
          state_nxt     = WAIT;
`ifdef SDR_ARB_TIMEOUT_EN
          cnt_nxt       = '0;
`endif
        end
      end
      WAIT: begin
        if (sdr_ack == sdr_req) begin
          if (owner_rom) rom_ack_nxt = rom_req;
          else           cpu_ack_nxt = cpu_req;
          if (!owner_rom && sdr_rnw) cpu_q_nxt = sdr_q;
          state_nxt = IDLE;
        end
`ifdef SDR_ARB_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT - 1)) begin
          // Withdraw the request and release the requester without new read data.
          timeout_err_nxt = 1'b1;
          sdr_req_nxt     = sdr_ack;
          if (owner_rom) rom_ack_nxt = rom_req;
          else           cpu_ack_nxt = cpu_req;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner_rom <= 1'b0;
      cpu_ack   <= 1'b0;
      rom_ack   <= 1'b0;
      sdr_req   <= 1'b0;
      sdr_rnw   <= 1'b1;
      sdr_addr  <= '0;
      sdr_din   <= '0;
      sdr_be    <= '0;
      cpu_q     <= '0;
    end else begin
      state     <= state_nxt;
      owner_rom <= owner_rom_nxt;
      cpu_ack   <= cpu_ack_nxt;
      rom_ack   <= rom_ack_nxt;
      sdr_req   <= sdr_req_nxt;
      sdr_rnw   <= sdr_rnw_nxt;
      sdr_addr  <= sdr_addr_nxt;
      sdr_din   <= sdr_din_nxt;
      sdr_be    <= sdr_be_nxt;
      cpu_q     <= cpu_q_nxt;
    end
  end

`ifdef SDR_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end
`endif

endmodule

// File: doc/sdr_ch3_arbiter.md
# sdr_ch3_arbiter

Arbitrates SDRAM channel 3 between the 68000-side CPU requester and the ROM loader, replacing the static busy-based mux in front of the sdram controller. Both requesters and the controller use toggle handshakes: a request is pending while `req != ack`. The arbiter latches one request at a time, forwards it, and completes the requester's handshake only after the controller acknowledges. It never fabricates acks, so CPU accesses made while loading are held, not dropped.

## Interface
Parameters:
- AW, 27, address width
- DW, 16, write data width
- QW, 64, read data width
- TIMEOUT, 4095, downstream wait limit in clk cycles (used only with SDR_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rom_load_busy  in  1  ROM load in progress; selects priority
- cpu_addr / rom_addr  in  AW  request address
- cpu_din / rom_din  in  DW  write data
- cpu_be / rom_be  in  2  byte enables
- cpu_rw / rom_rw  in  1  1 = read, 0 = write
- cpu_req / rom_req  in  1  toggle request
- cpu_ack / rom_ack  out  1  toggle acknowledge
- cpu_q  out  QW  last CPU read data
- sdr_addr  out  AW, sdr_din  out  DW, sdr_be  out  2, sdr_rnw  out  1  latched command to the controller
- sdr_req  out  1  toggle request to the controller
- sdr_ack  in  1  toggle acknowledge from the controller
- sdr_q  in  QW  controller read data
- timeout_err  out  1  sticky downstream timeout flag

## Operation
- Pending: `cpu_pend = cpu_req ^ cpu_ack`, `rom_pend = rom_req ^ rom_ack`.
- States: IDLE, WAIT.
- IDLE:
  - If any request is pending, select the winner:
    - rom_load_busy=1: ROM first.
    - rom_load_busy=0: CPU first.
    - The loser stays pending; nothing is discarded.
  - Latch the winner's addr/din/be/rw into sdr_*, record the owner, toggle sdr_req, go to WAIT.
- WAIT:
  - When `sdr_ack == sdr_req`:
    - Set the owner's ack equal to its req.
    - If the owner is CPU and rw=1, load sdr_q into cpu_q.
    - Return to IDLE.
- A requester toggling req again before its ack has toggled is a protocol violation; behaviour is undefined.
- rom_load_busy changing during WAIT does not affect the access in flight.
- A ROM request still pending when rom_load_busy falls is serviced at CPU priority. This lets the final loader write complete.
- sdr_* command outputs hold their value outside WAIT.

## Timing
- Reset values: cpu_ack=0, rom_ack=0, sdr_req=0, sdr_addr/din/be=0, sdr_rnw=1, cpu_q=0, timeout_err=0, state IDLE.
- A requester whose req is 1 at reset release is treated as pending.
- Request seen pending at edge N → sdr_req toggles at edge N+1.
- sdr_ack match seen at edge M → owner ack toggles and cpu_q updates at edge M+1.
- Minimum turnaround with an immediate controller ack: 3 cycles req→ack. The next grant can start on the edge after completion (IDLE occupies one cycle).
- Both requesters pending together: served back-to-back in priority order. Back-to-back re-requests from the CPU while rom_load_busy=1 and the ROM is continuously pending are starved by design.
- reset_n asserted mid-WAIT: everything returns to reset values immediately. Requesters and the controller are reset by the same reset.

## Configuration
- SDR_ARB_TIMEOUT_EN defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT without a match:
    - Set timeout_err (sticky until reset).
    - Force sdr_req = sdr_ack to withdraw the request.
    - Complete the owner's handshake; cpu_q is unchanged.
    - Return to IDLE.
- Undefined: no counter. timeout_err is constant 0, WAIT lasts indefinitely, and TIMEOUT is ignored.

## Test plan
- CPU read, addr 0x0100000, controller acks after 5 cycles with sdr_q=0x1122334455667788 → sdr_rnw=1, sdr_addr=0x0100000; cpu_ack toggles 1 cycle after the match; cpu_q=0x1122334455667788.
- rom_load_busy=1, ROM write addr 0x0000002 din 0xBEEF be=2'b11, plus a simultaneous CPU read → ROM issued first; CPU issued only after rom_ack toggles; cpu_ack not toggled before then.
- rom_load_busy=0 with both pending → CPU granted first, then ROM; the ROM write completes normally.
- Controller acks instantly, 8 consecutive CPU requests → each req→ack takes 3 cycles; sdr_req toggles exactly 8 times.
- reset_n pulsed low during WAIT → all outputs at reset values within the same cycle; no ack toggle after release while requesters' req=0.
- With SDR_ARB_TIMEOUT_EN, TIMEOUT=16, controller never acks → at cycle 16 of WAIT, timeout_err=1, sdr_req==sdr_ack, cpu_ack toggled, cpu_q unchanged; without the macro → still in WAIT after 10000 cycles, timeout_err=0.
